// File: rtl/nios_system_sysid_checker.sv
// ---------------------------------------------------------------------------
// nios_system_sysid_checker
// Reads the system-ID word and build timestamp over Avalon-MM and reports
// pass/fail/timeout status. Optional macro: SYSID_CHECK_TS_EN (timestamp read).
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module nios_system_sysid_checker #(
   parameter logic [31:0] EXPECTED_ID        = 32'd0,
   parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1581413303,
   parameter int unsigned TIMEOUT_CYCLES     = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        address,
   output logic        read,
   input  logic [31:0] readdata,
   input  logic        waitrequest,
   output logic        done,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        timeout,
   output logic [31:0] captured_id,
   output logic [31:0] captured_ts
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RD_ID = 3'd1,
      S_RD_TS = 3'd2,
      S_CHECK = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   // Counter value at which one more stalled cycle abandons the read
   localparam logic [7:0] c_tmo_last = 8'(TIMEOUT_CYCLES - 1);

   state_t      r_state;
   state_t      w_next_state;
   logic [7:0]  r_tmo_cnt;
   logic        r_done;
   logic        r_id_ok;
   logic        r_ts_ok;
   logic        r_timeout;
   logic [31:0] r_captured_id;
   logic        w_in_read;
   logic        w_tmo_hit;

   assign w_in_read = (r_state == S_RD_ID) || (r_state == S_RD_TS);
   assign w_tmo_hit = w_in_read && waitrequest && (r_tmo_cnt == c_tmo_last);

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  w_next_state = S_RD_ID;
         S_RD_ID: begin
            if (w_tmo_hit)
               w_next_state = S_DONE;
            else if (!waitrequest)
`ifdef SYSID_CHECK_TS_EN
               w_next_state = S_RD_TS;
`else
               w_next_state = S_CHECK;
`endif
         end
`ifdef SYSID_CHECK_TS_EN
         S_RD_TS: begin
            if (w_tmo_hit)
               w_next_state = S_DONE;
            else if (!waitrequest)
               w_next_state = S_CHECK;
         end
`endif
         S_CHECK: w_next_state = S_DONE;
         S_DONE:  if (start) w_next_state = S_RD_ID;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_tmo_cnt     <= 8'd0;
         r_done        <= 1'b0;
         r_id_ok       <= 1'b0;
         r_ts_ok       <= 1'b0;
         r_timeout     <= 1'b0;
         r_captured_id <= 32'd0;
      end else begin
         r_state <= w_next_state;
         // Counter runs only while a read stays stalled; any state change clears it
         if (w_in_read && waitrequest && (w_next_state == r_state))
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
         else
            r_tmo_cnt <= 8'd0;

         case (r_state)
            S_RD_ID: if (!waitrequest) r_captured_id <= readdata;
            S_CHECK: begin
               r_done  <= 1'b1;
               r_id_ok <= (r_captured_id == EXPECTED_ID);
`ifdef SYSID_CHECK_TS_EN
               r_ts_ok <= (r_captured_ts == EXPECTED_TIMESTAMP);
`else
               r_ts_ok <= 1'b1;
`endif
            end
            S_DONE: begin
               if (start) begin
                  r_done    <= 1'b0;
                  r_id_ok   <= 1'b0;
                  r_ts_ok   <= 1'b0;
                  r_timeout <= 1'b0;
               end
            end
            default: ;
         endcase

         if (w_tmo_hit) begin
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
            r_id_ok   <= 1'b0;
            r_ts_ok   <= 1'b0;
         end
      end
   end

`ifdef SYSID_CHECK_TS_EN
   logic [31:0] r_captured_ts;

   always_ff @(posedge clock) begin
      if (reset)
         r_captured_ts <= 32'd0;
      else if ((r_state == S_RD_TS) && !waitrequest)
         r_captured_ts <= readdata;
   end

   assign address     = (r_state == S_RD_TS);
   assign captured_ts = r_captured_ts;
`else
   logic w_unused_ts_cfg;

   assign w_unused_ts_cfg = (EXPECTED_TIMESTAMP == 32'd0);
   assign address         = 1'b0;
   assign captured_ts     = 32'd0;
`endif

   assign read        = w_in_read;
   assign done        = r_done;
   assign id_ok       = r_id_ok;
   assign ts_ok       = r_ts_ok;
   assign timeout     = r_timeout;
   assign captured_id = r_captured_id;

endmodule

`default_nettype wire
